// File: rtl/sdram_chip_model.sv
// rtl/sdram_chip_model.sv - single-rank 16-bit SDR SDRAM device model
//
// Purpose: device end of the SDRAM pin bus. Decodes CS/RAS/CAS/WE commands,
// tracks the open row per bank, honours the mode register (BL, CL, single
// write) and serves reads/writes from an internal word array.
//
// Ports:
//   clock        in   single clock, rising edge
//   reset        in   synchronous, active-high
//   sdram_cke    in   clock enable; 0 freezes all state and outputs
//   sdram_cs     in   chip select, active low
//   sdram_ras    in   row strobe, active low
//   sdram_cas    in   column strobe, active low
//   sdram_we     in   write enable, active low
//   sdram_a      in   row / column / mode address; a[10] auto-precharge / all banks
//   sdram_ba     in   bank select
//   sdram_dqm    in   write byte mask ([1] -> dq[15:8], [0] -> dq[7:0])
//   sdram_dq_i   in   write data
//   sdram_dq_o   out  read data (0 when no beat is due)
//   sdram_dq_oe  out  device drives the dq bus
//   err_o        out  sticky protocol-violation flag
module sdram_chip_model #(
  parameter int ROW_W      = 13,
  parameter int COL_W      = 9,
  parameter int MEM_ADDR_W = 16,
  parameter int CL_RESET   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sdram_cke,
  input  logic        sdram_cs,
  input  logic        sdram_ras,
  input  logic        sdram_cas,
  input  logic        sdram_we,
  input  logic [12:0] sdram_a,
  input  logic [1:0]  sdram_ba,
  input  logic [1:0]  sdram_dqm,
  input  logic [15:0] sdram_dq_i,
  output logic [15:0] sdram_dq_o,
  output logic        sdram_dq_oe,
  output logic        err_o
);

  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_t;

  logic [15:0]           mem [2**MEM_ADDR_W];

  logic [3:0]            bank_open;
  logic [ROW_W-1:0]      bank_row [4];
  logic [1:0]            bl_log;
  logic                  cl3;
  logic                  wr_single;

  // Burst in progress: beats after beat 0, which is issued straight from the command.
  logic                  burst_act;
  logic                  burst_wr;
  logic                  burst_ap;
  logic [1:0]            burst_ba;
  logic [ROW_W-1:0]      burst_row;
  logic [COL_W-1:0]      burst_col;
  logic [3:0]            burst_left;

  // CAS pipeline: CL3 reads enter at mid, CL2 reads enter at out.
  logic                  pipe_mid_v;
  logic                  pipe_out_v;
  logic [MEM_ADDR_W-1:0] pipe_mid_a;
  logic [MEM_ADDR_W-1:0] pipe_out_a;

  cmd_t                  cmd;
  logic                  new_burst;
  logic [3:0]            new_len;
  logic                  issue_v;
  logic                  issue_wr;
  logic                  issue_last;
  logic                  issue_ap;
  logic [1:0]            issue_ba;
  logic [ROW_W-1:0]      issue_row;
  logic [COL_W-1:0]      issue_col;
  logic [MEM_ADDR_W-1:0] issue_addr;
  logic                  rd_issue;
  logic                  wr_issue;

  // Advance the column inside its BL-aligned block (wrap on the low bits only).
  function automatic logic [COL_W-1:0] next_col(input logic [COL_W-1:0] col,
                                                input logic [1:0]       lg);
    logic [COL_W-1:0] mask;
    mask = (COL_W'(1) << lg) - COL_W'(1);
    return (col & ~mask) | ((col + COL_W'(1)) & mask);
  endfunction

  function automatic logic [MEM_ADDR_W-1:0] word_addr(input logic [1:0]       ba,
                                                      input logic [ROW_W-1:0] row,
                                                      input logic [COL_W-1:0] col);
    return MEM_ADDR_W'({ba, row, col});
  endfunction

  always_comb begin
    cmd       = (sdram_cke && !sdram_cs) ? cmd_t'({sdram_ras, sdram_cas, sdram_we}) : CMD_NOP;
    new_burst = ((cmd == CMD_WR) || (cmd == CMD_RD)) && bank_open[sdram_ba];
    new_len   = ((cmd == CMD_WR) && wr_single) ? 4'd1 : (4'd1 << bl_log);
    if (new_burst) begin
      issue_v    = 1'b1;
      issue_wr   = (cmd == CMD_WR);
      issue_ba   = sdram_ba;
      issue_row  = bank_row[sdram_ba];
      issue_col  = sdram_a[COL_W-1:0];
      issue_ap   = sdram_a[10];
      issue_last = (new_len == 4'd1);
    end else begin
      issue_v    = burst_act;
      issue_wr   = burst_wr;
      issue_ba   = burst_ba;
      issue_row  = burst_row;
      issue_col  = burst_col;
      issue_ap   = burst_ap;
      issue_last = (burst_left == 4'd1);
    end
    issue_addr = word_addr(issue_ba, issue_row, issue_col);
    rd_issue   = issue_v && !issue_wr;
    wr_issue   = issue_v && issue_wr;
  end

  // The array has no reset: its contents survive reset and start undefined.
  always_ff @(posedge clock) begin
    if (!reset && sdram_cke && wr_issue) begin
      if (!sdram_dqm[0]) mem[issue_addr][7:0]  <= sdram_dq_i[7:0];
      if (!sdram_dqm[1]) mem[issue_addr][15:8] <= sdram_dq_i[15:8];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bank_open <= '0;
      for (int b = 0; b < 4; b++) bank_row[b] <= '0;
      bl_log      <= 2'd0;
      cl3         <= (CL_RESET == 3);
      wr_single   <= 1'b0;
      burst_act   <= 1'b0;
      burst_wr    <= 1'b0;
      burst_ap    <= 1'b0;
      burst_ba    <= 2'd0;
      burst_row   <= '0;
      burst_col   <= '0;
      burst_left  <= 4'd0;
      pipe_mid_v  <= 1'b0;
      pipe_out_v  <= 1'b0;
      pipe_mid_a  <= '0;
      pipe_out_a  <= '0;
      sdram_dq_o  <= 16'd0;
      sdram_dq_oe <= 1'b0;
      err_o       <= 1'b0;
    end else if (sdram_cke) begin
      pipe_mid_v  <= rd_issue && cl3;
      pipe_mid_a  <= issue_addr;
      pipe_out_v  <= cl3 ? pipe_mid_v : rd_issue;
      pipe_out_a  <= cl3 ? pipe_mid_a : issue_addr;
      sdram_dq_oe <= pipe_out_v;
      sdram_dq_o  <= pipe_out_v ? mem[pipe_out_a] : 16'd0;

      if (new_burst) begin
        burst_act  <= (new_len != 4'd1);
        burst_wr   <= issue_wr;
        burst_ap   <= issue_ap;
        burst_ba   <= issue_ba;
        burst_row  <= issue_row;
        burst_col  <= next_col(issue_col, bl_log);
        burst_left <= new_len - 4'd1;
      end else if (burst_act) begin
        burst_act  <= (burst_left != 4'd1);
        burst_left <= burst_left - 4'd1;
        burst_col  <= next_col(burst_col, bl_log);
      end
      // The beat due at this edge is still issued; later beats are dropped.
      if ((cmd == CMD_BST) || (cmd == CMD_PRE)) burst_act <= 1'b0;

      if (issue_v && issue_last && issue_ap) bank_open[issue_ba] <= 1'b0;

      case (cmd)
        CMD_MRS: begin
          if (|bank_open) begin
            err_o <= 1'b1;
          end else begin
            if (sdram_a[2]) err_o <= 1'b1;
            else            bl_log <= sdram_a[1:0];
            if (sdram_a[3]) err_o <= 1'b1;
            if (sdram_a[6:4] == 3'd2)      cl3 <= 1'b0;
            else if (sdram_a[6:4] == 3'd3) cl3 <= 1'b1;
            else                           err_o <= 1'b1;
            wr_single <= sdram_a[9];
          end
        end
        CMD_REF: if (|bank_open) err_o <= 1'b1;
        CMD_PRE: begin
          if (sdram_a[10]) bank_open <= '0;
          else             bank_open[sdram_ba] <= 1'b0;
        end
        CMD_ACT: begin
          if (bank_open[sdram_ba]) err_o <= 1'b1;
          bank_open[sdram_ba] <= 1'b1;
          bank_row[sdram_ba]  <= sdram_a[ROW_W-1:0];
        end
        CMD_WR, CMD_RD: if (!bank_open[sdram_ba]) err_o <= 1'b1;
        default: ;
      endcase

      // A write beat landing while the device drives dq is a bus collision.
      if (wr_issue && sdram_dq_oe) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_chip_model.sv
// tb/tb_sdram_chip_model.sv - self-checking bench for sdram_chip_model
module tb_sdram_chip_model;

  localparam int ROW_W      = 13;
  localparam int COL_W      = 9;
  localparam int MEM_ADDR_W = 16;

  localparam logic [2:0] C_MRS = 3'b000;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_BST = 3'b110;
  localparam logic [2:0] C_NOP = 3'b111;

  logic        clock = 1'b0;
  logic        reset;
  logic        sdram_cke;
  logic        sdram_cs;
  logic        sdram_ras;
  logic        sdram_cas;
  logic        sdram_we;
  logic [12:0] sdram_a;
  logic [1:0]  sdram_ba;
  logic [1:0]  sdram_dqm;
  logic [15:0] sdram_dq_i;
  logic [15:0] sdram_dq_o;
  logic        sdram_dq_oe;
  logic        err_o;

  always #5 clock = ~clock;

  sdram_chip_model #(
    .ROW_W(ROW_W), .COL_W(COL_W), .MEM_ADDR_W(MEM_ADDR_W), .CL_RESET(2)
  ) dut (
    .clock(clock), .reset(reset), .sdram_cke(sdram_cke), .sdram_cs(sdram_cs),
    .sdram_ras(sdram_ras), .sdram_cas(sdram_cas), .sdram_we(sdram_we),
    .sdram_a(sdram_a), .sdram_ba(sdram_ba), .sdram_dqm(sdram_dqm),
    .sdram_dq_i(sdram_dq_i), .sdram_dq_o(sdram_dq_o), .sdram_dq_oe(sdram_dq_oe),
    .err_o(err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bits the reference holds as unknown (never-written bytes) are not compared.
  task automatic check_dq(input string name, input logic [15:0] act, input logic [15:0] exp);
    logic [15:0] am, em;
    for (int k = 0; k < 16; k++) begin
      if (exp[k] === 1'bx) begin am[k] = 1'b0; em[k] = 1'b0; end
      else begin am[k] = act[k]; em[k] = exp[k]; end
    end
    check(name, am, em);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int edge_n;
    bit wr;
    int addr;
    bit ap;
    int bank;
    bit last;
  } beat_t;

  beat_t       pend[$];
  int          sched [int];
  logic [15:0] mm [int];
  bit          m_open [4];
  int          m_row [4];
  int          m_bl, m_cl;
  bit          m_single;
  bit          m_oe, m_err;
  logic [15:0] m_dq;
  int          t = 0;

  function automatic int model_addr(input int b, input int row, input int col);
    return ((b << (ROW_W + COL_W)) + (row << COL_W) + col) % (1 << MEM_ADDR_W);
  endfunction

  task automatic model_reset();
    pend.delete();
    sched.delete();
    for (int b = 0; b < 4; b++) begin m_open[b] = 0; m_row[b] = 0; end
    m_bl = 1; m_cl = 2; m_single = 0;
    m_oe = 0; m_dq = 16'd0; m_err = 0;
  endtask

  task automatic model_step();
    bit          prev_oe;
    bit          any_open;
    int          c, len, col, b;
    beat_t       bt;
    logic [15:0] w;
    t++;
    prev_oe = m_oe;
    if (sched.exists(t)) begin
      m_oe = 1;
      m_dq = mm.exists(sched[t]) ? mm[sched[t]] : 16'hxxxx;
      sched.delete(t);
    end else begin
      m_oe = 0;
      m_dq = 16'd0;
    end
    c  = sdram_cs ? 7 : int'({sdram_ras, sdram_cas, sdram_we});
    b  = int'(sdram_ba);
    any_open = m_open[0] | m_open[1] | m_open[2] | m_open[3];
    if (c == 4 || c == 5) begin
      if (!m_open[b]) m_err = 1;
      else begin
        pend.delete();
        len = (c == 4 && m_single) ? 1 : m_bl;
        col = int'(sdram_a[COL_W-1:0]);
        for (int i = 0; i < len; i++) begin
          bt.edge_n = t + i;
          bt.wr     = (c == 4);
          bt.addr   = model_addr(b, m_row[b], (col / m_bl) * m_bl + (col % m_bl + i) % m_bl);
          bt.ap     = sdram_a[10];
          bt.bank   = b;
          bt.last   = (i == len - 1);
          pend.push_back(bt);
        end
      end
    end
    if (pend.size() > 0 && pend[0].edge_n == t) begin
      bt = pend.pop_front();
      if (bt.wr) begin
        if (prev_oe) m_err = 1;
        w = mm.exists(bt.addr) ? mm[bt.addr] : 16'hxxxx;
        if (!sdram_dqm[0]) w[7:0]  = sdram_dq_i[7:0];
        if (!sdram_dqm[1]) w[15:8] = sdram_dq_i[15:8];
        mm[bt.addr] = w;
      end else begin
        sched[t + m_cl - 1] = bt.addr;
      end
      if (bt.ap && bt.last) m_open[bt.bank] = 0;
    end
    case (c)
      0: begin
        if (any_open) m_err = 1;
        else begin
          if (sdram_a[2:0] <= 3) m_bl = 1 << sdram_a[2:0]; else m_err = 1;
          if (sdram_a[3]) m_err = 1;
          if (sdram_a[6:4] == 2 || sdram_a[6:4] == 3) m_cl = int'(sdram_a[6:4]); else m_err = 1;
          m_single = sdram_a[9];
        end
      end
      1: if (any_open) m_err = 1;
      2: begin
        pend.delete();
        if (sdram_a[10]) for (int k = 0; k < 4; k++) m_open[k] = 0;
        else m_open[b] = 0;
      end
      3: begin
        if (m_open[b]) m_err = 1;
        m_open[b] = 1;
        m_row[b]  = int'(sdram_a[ROW_W-1:0]);
      end
      6: pend.delete();
      default: ;
    endcase
  endtask

  always @(posedge clock) begin
    if (reset) model_reset();
    else if (sdram_cke) model_step();
  end

  always @(negedge clock) begin
    if (checking) begin
      check("model_oe", {15'd0, sdram_dq_oe}, {15'd0, m_oe});
      check("model_err", {15'd0, err_o}, {15'd0, m_err});
      check_dq("model_dq", sdram_dq_o, m_dq);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic k, input logic c_s, input logic [2:0] c, input logic [1:0] b,
                       input logic [12:0] addr, input logic [15:0] d, input logic [1:0] m);
    sdram_cke  = k;
    sdram_cs   = c_s;
    {sdram_ras, sdram_cas, sdram_we} = c;
    sdram_ba   = b;
    sdram_a    = addr;
    sdram_dq_i = d;
    sdram_dqm  = m;
    @(posedge clock);
    #1;
  endtask

  task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [12:0] addr,
                     input logic [15:0] d, input logic [1:0] m);
    drive(1'b1, 1'b0, c, b, addr, d, m);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cmd(C_NOP, 2'd0, 13'd0, 16'd0, 2'd0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    nop(n);
    reset = 1'b0;
  endtask

  task automatic random_op();
    int          r;
    logic [1:0]  b, m;
    logic [15:0] d;
    logic [12:0] col, row;
    r   = $urandom_range(0, 99);
    b   = 2'($urandom_range(0, 3));
    d   = 16'($urandom);
    m   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
    col = 13'($urandom_range(0, 15));
    row = 13'($urandom_range(0, 3));
    if (r < 30)      cmd(C_NOP, b, col, d, m);
    else if (r < 38) drive(1'b0, 1'($urandom), 3'($urandom), b, col, d, m);
    else if (r < 46) cmd(C_ACT, b, row, d, m);
    else if (r < 68) cmd(C_WR, b, col, d, m);
    else if (r < 88) cmd(C_RD, b, col, d, m);
    else if (r < 92) cmd(C_BST, b, col, d, m);
    else if (r < 97) cmd(C_PRE, b, {2'b00, 1'($urandom), 10'd0}, d, m);
    else             cmd(C_REF, b, col, d, m);
  endtask

  initial begin
    reset = 1'b1;
    sdram_cke = 1'b1; sdram_cs = 1'b1;
    {sdram_ras, sdram_cas, sdram_we} = C_NOP;
    sdram_a = '0; sdram_ba = '0; sdram_dqm = '0; sdram_dq_i = '0;
    @(posedge clock);
    #1;
    checking = 1;
    nop(2);
    reset = 1'b0;
    check("reset_oe", {15'd0, sdram_dq_oe}, 16'd0);
    check("reset_dq", sdram_dq_o, 16'd0);
    check("reset_err", {15'd0, err_o}, 16'd0);

    // CL2 BL1 write then read
    cmd(C_MRS, 2'd0, 13'h020, 16'd0, 2'd0);
    cmd(C_ACT, 2'd1, 13'h0123, 16'd0, 2'd0);
    cmd(C_WR,  2'd1, 13'h010, 16'hBEEF, 2'd0);
    cmd(C_RD,  2'd1, 13'h010, 16'd0, 2'd0);
    check("t1_oe_early", {15'd0, sdram_dq_oe}, 16'd0);
    nop(1);
    check("t1_oe", {15'd0, sdram_dq_oe}, 16'd1);
    check("t1_data", sdram_dq_o, 16'hBEEF);
    nop(1);
    check("t1_oe_after", {15'd0, sdram_dq_oe}, 16'd0);
    check("t1_err", {15'd0, err_o}, 16'd0);

    // CL3 BL4 wrapped burst write and read
    cmd(C_PRE, 2'd0, 13'h0400, 16'd0, 2'd0);
    cmd(C_MRS, 2'd0, 13'h032, 16'd0, 2'd0);
    cmd(C_ACT, 2'd1, 13'h0123, 16'd0, 2'd0);
    cmd(C_WR,  2'd1, 13'h006, 16'd1, 2'd0);
    cmd(C_NOP, 2'd0, 13'd0, 16'd2, 2'd0);
    cmd(C_NOP, 2'd0, 13'd0, 16'd3, 2'd0);
    cmd(C_NOP, 2'd0, 13'd0, 16'd4, 2'd0);
    cmd(C_RD,  2'd1, 13'h004, 16'd0, 2'd0);
    nop(1);
    check("t2_oe_cl3", {15'd0, sdram_dq_oe}, 16'd0);
    nop(1); check("t2_beat0", sdram_dq_o, 16'd3);
    nop(1); check("t2_beat1", sdram_dq_o, 16'd4);
    nop(1); check("t2_beat2", sdram_dq_o, 16'd1);
    nop(1); check("t2_beat3", sdram_dq_o, 16'd2);
    nop(1); check("t2_oe_end", {15'd0, sdram_dq_oe}, 16'd0);

    // byte mask
    cmd(C_WR, 2'd1, 13'h020, 16'hAAAA, 2'd0);
    for (int i = 0; i < 3; i++) cmd(C_NOP, 2'd0, 13'd0, 16'hAAAA, 2'd0);
    cmd(C_WR, 2'd1, 13'h020, 16'h5555, 2'b10);
    for (int i = 0; i < 3; i++) cmd(C_NOP, 2'd0, 13'd0, 16'h5555, 2'b10);
    cmd(C_RD, 2'd1, 13'h020, 16'd0, 2'd0);
    nop(2);
    check("t3_mask", sdram_dq_o, 16'hAA55);
    nop(5);

    // burst terminate one edge after a CL2 BL4 read
    cmd(C_PRE, 2'd0, 13'h0400, 16'd0, 2'd0);
    cmd(C_MRS, 2'd0, 13'h022, 16'd0, 2'd0);
    cmd(C_ACT, 2'd1, 13'h0123, 16'd0, 2'd0);
    cmd(C_RD,  2'd1, 13'h020, 16'd0, 2'd0);
    check("t4_oe0", {15'd0, sdram_dq_oe}, 16'd0);
    cmd(C_BST, 2'd0, 13'd0, 16'd0, 2'd0);
    check("t4_beat0", sdram_dq_o, 16'hAA55);
    nop(1);
    check("t4_beat1_oe", {15'd0, sdram_dq_oe}, 16'd1);
    nop(1);
    check("t4_stopped", {15'd0, sdram_dq_oe}, 16'd0);
    nop(2);
    check("t4_still_stopped", {15'd0, sdram_dq_oe}, 16'd0);

    // read to a closed bank
    cmd(C_RD, 2'd2, 13'h000, 16'd0, 2'd0);
    check("t5_err", {15'd0, err_o}, 16'd1);
    nop(3);
    check("t5_no_oe", {15'd0, sdram_dq_oe}, 16'd0);
    check("t5_sticky", {15'd0, err_o}, 16'd1);

    // reset mid burst
    do_reset(2);
    cmd(C_MRS, 2'd0, 13'h022, 16'd0, 2'd0);
    cmd(C_ACT, 2'd1, 13'h0123, 16'd0, 2'd0);
    cmd(C_RD,  2'd1, 13'h020, 16'd0, 2'd0);
    nop(1);
    check("t6_oe_before", {15'd0, sdram_dq_oe}, 16'd1);
    do_reset(1);
    check("t6_oe_reset", {15'd0, sdram_dq_oe}, 16'd0);
    check("t6_err_reset", {15'd0, err_o}, 16'd0);
    cmd(C_RD, 2'd1, 13'h020, 16'd0, 2'd0);
    check("t6_err_closed", {15'd0, err_o}, 16'd1);
    nop(3);

    // randomized traffic against the reference model
    for (int blk = 0; blk < 40; blk++) begin
      do_reset(2);
      cmd(C_MRS, 2'd0,
          {3'd0, ($urandom_range(0, 3) == 0), 2'd0, ($urandom_range(0, 1) ? 3'd3 : 3'd2),
           1'b0, 3'($urandom_range(0, 3))},
          16'd0, 2'd0);
      for (int i = 0; i < 60; i++) random_op();
    end
    nop(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
